// File: rtl/ldl_rr_pkg.sv
// Shared constants and helpers for the ldl round-robin arbiter.
package ldl_rr_pkg;

    localparam int unsigned BIN_WIDTH_DEF = 3;

    // Requester count is always a power of two derived from the index width.
    function automatic int unsigned req_width(input int unsigned bw);
        return 32'(1) << bw;
    endfunction

endpackage

// File: rtl/ldl_rr_pick.sv
// Combinational round-robin pick: first set request after the last-grant pointer, wrapping.
module ldl_rr_pick
    import ldl_rr_pkg::*;
#(
    parameter int unsigned BIN_WIDTH = BIN_WIDTH_DEF,
    localparam int unsigned REQ_WIDTH = req_width(BIN_WIDTH)
) (
    input  logic [REQ_WIDTH-1:0] req,
    input  logic [BIN_WIDTH-1:0] last,
    output logic                 any,
    output logic [REQ_WIDTH-1:0] gnt,
    output logic [BIN_WIDTH-1:0] idx
);

    logic [BIN_WIDTH:0]   sh;
    logic [REQ_WIDTH-1:0] rot;
    logic [BIN_WIDTH-1:0] off;

    // Rotate so that index last+1 lands at bit 0.
    assign sh  = {1'b0, last} + (BIN_WIDTH+1)'(1);
    assign rot = REQ_WIDTH'({req, req} >> sh);

    // Descending scan leaves the lowest set rotated bit in off.
    always_comb begin
        off = '0;
        for (int i = REQ_WIDTH - 1; i >= 0; i--) begin
            if (rot[i]) off = BIN_WIDTH'(i);
        end
    end

    // Rotate back; modulo wrap falls out of the power-of-two index width.
    assign any = |req;
    assign idx = last + BIN_WIDTH'(1) + off;
    assign gnt = any ? (REQ_WIDTH'(1) << idx) : '0;

endmodule

// File: rtl/ldl_rr_arbiter.sv
// Round-robin arbiter with registered valid/ready grant stage (one-hot and binary grant).
module ldl_rr_arbiter
    import ldl_rr_pkg::*;
#(
    parameter int unsigned BIN_WIDTH = BIN_WIDTH_DEF,
    localparam int unsigned REQ_WIDTH = req_width(BIN_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REQ_WIDTH-1:0] req,
    input  logic                 ready,
    output logic                 valid,
    output logic [REQ_WIDTH-1:0] ack,
    output logic [BIN_WIDTH-1:0] bin
);

    logic [BIN_WIDTH-1:0] last;
    logic                 load;
    logic                 pick_any;
    logic [REQ_WIDTH-1:0] pick_gnt;
    logic [BIN_WIDTH-1:0] pick_idx;

    ldl_rr_pick #(
        .BIN_WIDTH (BIN_WIDTH)
    ) u_pick (
        .req  (req),
        .last (last),
        .any  (pick_any),
        .gnt  (pick_gnt),
        .idx  (pick_idx)
    );

    // Slot is empty or being accepted this edge.
    assign load = !valid || ready;

    // Output stage and pointer; a held grant stays put until accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            ack   <= '0;
            bin   <= '0;
            last  <= BIN_WIDTH'(REQ_WIDTH - 1);
        end else if (load) begin
            if (pick_any) begin
                valid <= 1'b1;
                ack   <= pick_gnt;
                bin   <= pick_idx;
                last  <= pick_idx;
            end else begin
                valid <= 1'b0;
                ack   <= '0;
                bin   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ldl_rr_arbiter.sv
// Directed self-checking bench for ldl_rr_arbiter (default 8 requesters).
module tb_ldl_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       ready;
    logic       valid;
    logic [7:0] ack;
    logic [2:0] bin;

    int total;
    int passed;

    ldl_rr_arbiter #(
        .BIN_WIDTH (3)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .ready (ready),
        .valid (valid),
        .ack   (ack),
        .bin   (bin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic ev, input logic [7:0] ea, input logic [2:0] eb);
        total++;
        assert (valid === ev && ack === ea && bin === eb) passed++;
        else $error("FAIL %s: got valid=%0b ack=%02h bin=%0d, want valid=%0b ack=%02h bin=%0d",
                    tag, valid, ack, bin, ev, ea, eb);
    endtask

    initial begin
        total  = 0;
        passed = 0;
        rst    = 1'b0;
        req    = 8'h00;
        ready  = 1'b1;

        // Reset held, then released with no requests
        step();
        step();
        chk("reset", 1'b0, 8'h00, 3'd0);
        rst = 1'b1;
        step(); chk("idle0", 1'b0, 8'h00, 3'd0);
        step(); chk("idle1", 1'b0, 8'h00, 3'd0);

        // Single persistent requester
        req = 8'h01;
        step(); chk("single0", 1'b1, 8'h01, 3'd0);
        step(); chk("single1", 1'b1, 8'h01, 3'd0);
        step(); chk("single2", 1'b1, 8'h01, 3'd0);

        // Two requesters alternate, last grant was 0
        req = 8'h03;
        step(); chk("pair0", 1'b1, 8'h02, 3'd1);
        step(); chk("pair1", 1'b1, 8'h01, 3'd0);
        step(); chk("pair2", 1'b1, 8'h02, 3'd1);
        step(); chk("pair3", 1'b1, 8'h01, 3'd0);

        // 0xA5 rotation from last=0: 2,5,7,0(wrap),2
        req = 8'hA5;
        step(); chk("rot2", 1'b1, 8'h04, 3'd2);
        step(); chk("rot5", 1'b1, 8'h20, 3'd5);
        step(); chk("rot7", 1'b1, 8'h80, 3'd7);
        step(); chk("rot0wrap", 1'b1, 8'h01, 3'd0);
        step(); chk("rot2b", 1'b1, 8'h04, 3'd2);

        // One cycle of backpressure holds the grant, then resumes at 5
        ready = 1'b0;
        step(); chk("hold", 1'b1, 8'h04, 3'd2);
        ready = 1'b1;
        step(); chk("resume5", 1'b1, 8'h20, 3'd5);
        step(); chk("resume7", 1'b1, 8'h80, 3'd7);
        step(); chk("resume0", 1'b1, 8'h01, 3'd0);

        // Requests vanish: valid drops one cycle later
        req = 8'h00;
        step(); chk("drop0", 1'b0, 8'h00, 3'd0);
        step(); chk("drop1", 1'b0, 8'h00, 3'd0);

        // Pointer kept at 0 across idle; held grant survives its req dropping
        req = 8'hA5;
        step(); chk("again2", 1'b1, 8'h04, 3'd2);
        ready = 1'b0;
        req   = 8'h00;
        step(); chk("norevoke", 1'b1, 8'h04, 3'd2);
        ready = 1'b1;
        step(); chk("release_empty", 1'b0, 8'h00, 3'd0);

        // Async reset mid-rotation clears outputs without a clock edge
        req = 8'hA5;
        step(); chk("pre_rst5", 1'b1, 8'h20, 3'd5);
        #2 rst = 1'b0;
        #1 chk("async_rst", 1'b0, 8'h00, 3'd0);
        step();
        rst   = 1'b1;
        ready = 1'b0;
        // Empty slot loads even with ready low; pointer back at 7 so bit 0 wins
        step(); chk("post_rst0", 1'b1, 8'h01, 3'd0);
        step(); chk("post_rst_hold", 1'b1, 8'h01, 3'd0);
        ready = 1'b1;
        step(); chk("post_rst2", 1'b1, 8'h04, 3'd2);

        // Wrap from high bit to low bit with sparse request
        req = 8'h81;
        step(); chk("wrap7", 1'b1, 8'h80, 3'd7);
        step(); chk("wrap0", 1'b1, 8'h01, 3'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ldl_rr_arbiter.md
# ldl_rr_arbiter

Parameterized round-robin arbiter with a registered valid/ready output stage. It grants one of `REQ_WIDTH` level-sensitive requesters per accepted transfer, in fair rotating order. It presents the grant both one-hot (`ack`) and binary-encoded (`bin`). It sits between a set of request sources and a single shared downstream consumer that applies backpressure via `ready`.

## Interface
- Clocking: one clock; reset is asynchronous and active-low.
- `BIN_WIDTH`, default 3: width of the binary grant index.
- `REQ_WIDTH`, default `1 << BIN_WIDTH` (8): number of requesters. Derived only; never overridden independently.
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: asynchronous, active-low reset.
- `req`, input, `REQ_WIDTH`: per-requester level request; bit i high means requester i wants service.
- `ready`, input, 1: downstream can accept the presented grant this cycle.
- `valid`, output, 1: `ack`/`bin` hold a live grant.
- `ack`, output, `REQ_WIDTH`: one-hot grant; all-zero when `valid` = 0.
- `bin`, output, `BIN_WIDTH`: binary index of the set `ack` bit; 0 when `valid` = 0.

## Operation
- State:
  - Output registers `valid`, `ack`, `bin`.
  - Last-grant pointer `last[BIN_WIDTH-1:0]`.
- Load condition: `load = !valid || ready`. This means the output slot is empty or is being accepted this cycle.
- On load:
  - Search `req` circularly, starting at index `last+1` (mod `REQ_WIDTH`) and ending at `last`.
  - The first set bit is the winner w.
  - Register `valid`=1, `ack`=1<<w, `bin`=w, `last`=w.
  - If `req`==0, register `valid`=0, `ack`=0, `bin`=0; `last` unchanged.
- When not loading (`valid`=1 and `ready`=0): `valid`, `ack`, `bin`, `last` hold exactly.
  - A held grant is not revoked, even if its `req` bit drops.
- Fairness:
  - The requester just granted gets lowest priority next.
  - A single persistent requester is granted every accepted cycle.
  - With k persistent requesters, each is granted once every k accepted transfers.
- Invariants:
  - `ack` has at most one bit set.
  - `ack == (valid ? 1<<bin : 0)`.
- The search wraps: index `REQ_WIDTH-1` is followed by index 0.

## Timing
- Reset values (asynchronous, while `rst`=0):
  - `valid`=0, `ack`=0, `bin`=0.
  - `last`=`REQ_WIDTH-1`, so bit 0 has top priority after reset.
- Latency: `req` sampled at edge N appears as `valid`/`ack`/`bin` after edge N (one cycle). There is no combinational path from inputs to outputs.
- Handshake: a transfer occurs on a rising edge with `valid`=1 and `ready`=1. The next grant is computed on that same edge, so back-to-back grants occur every cycle while `ready`=1.
- `ready`=0 with `valid`=0: the slot is empty, so a new grant still loads.
- `req` drops to 0 while `ready`=1: `valid` falls on the next edge.
- Reset asserted mid-operation: outputs clear immediately (asynchronously) and the pointer returns to `REQ_WIDTH-1`.

## Structure
- Shared package `ldl_rr_pkg`: the `BIN_WIDTH` default and a helper function computing `REQ_WIDTH` from `BIN_WIDTH`.
- One natural sub-module, `ldl_rr_pick`: purely combinational rotate-by-pointer priority pick.
  - Inputs: `req`, `last`.
  - Outputs: `any`, one-hot `gnt`, binary `idx`.
  - Implementation: rotate, then find first one, then rotate back, or the double-width masked method.
- Top level holds the output and pointer registers and the load logic.

## Test plan
- Reset with `req`=0, then release: `valid`=0, `ack`=0x00, `bin`=0 every cycle.
- `req`=0x01, `ready`=1: one cycle later `valid`=1, `ack`=0x01, `bin`=0, sustained every cycle.
- `req`=0x03, `ready`=1, last grant 0: `ack` sequence 0x02, 0x01, 0x02, 0x01…, with `bin` 1, 0, 1, 0….
- `req`=0xA5, `ready`=1: grants rotate through indices 0, 2, 5, 7 in cyclic order. Each of `ack`=0x01, 0x04, 0x20, 0x80 appears once per 4 cycles, with matching `bin`.
- During 0xA5 rotation, drive `ready`=0 for one cycle: `valid`/`ack`/`bin` hold their value for that cycle and the next edge. Rotation then resumes with the next index, none skipped or repeated.
- `req` returns to 0: one cycle later `valid`=0, `ack`=0x00, `bin`=0. Asserting `rst` mid-rotation clears outputs at once, and the first grant after release goes to the lowest set `req` bit.
